// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus an optional iterative
// shift-add multiplier, enabled by defining ALU_MUL_EN.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; in_ready only rises when the output slot is free or being drained.

`ifdef ALU_MUL_EN
  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;
`else
  typedef enum logic {IDLE = 1'b0} state_t;
`endif

  state_t state, state_next;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;
  logic             accept, mul_start, mul_done;
  logic [WIDTH-1:0] mul_res;

  assign shamt  = A[SHW-1:0];
  assign accept = in_valid & in_ready;

  always_comb begin
    sum     = A + B;
    diff    = A - B;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALU_operation)
      4'd0: alu_res = A & B;
      4'd1: alu_res = A | B;
      4'd2: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
      end
      4'd3: alu_res = A ^ B;
      4'd4: alu_res = ~(A | B);
      4'd5: alu_res = B >> shamt;
      4'd6: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) & (diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'd7: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      4'd8: alu_res = B << shamt;
      4'd9: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic               is_mul_op, hi_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc, acc_next, pp;

  assign is_mul_op = (ALU_operation == 4'd10) || (ALU_operation == 4'd11);
  assign mul_start = accept & is_mul_op;
  assign mul_done  = (state == MUL) && (cnt == LAST);

  // One partial product per cycle: add A shifted by the bit position of B.
  always_comb begin
    pp       = b_q[cnt] ? ({{WIDTH{1'b0}}, a_q} << cnt) : '0;
    acc_next = acc + pp;
    mul_res  = hi_q ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= 1'b0;
      acc  <= '0;
      cnt  <= '0;
    end else if (mul_start) begin
      a_q  <= A;
      b_q  <= B;
      hi_q <= (ALU_operation == 4'd11);
      acc  <= '0;
      cnt  <= '0;
    end else if (state == MUL) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign mul_start = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_res   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
`ifdef ALU_MUL_EN
    if ((state == IDLE) && mul_start) state_next = MUL;
    else if (mul_done)                state_next = IDLE;
`endif
  end

  always_comb begin
    in_ready = (state == IDLE) && (!out_valid || out_ready);
`ifdef ALU_MUL_EN
    busy = (state == MUL);
`else
    busy = 1'b0;
`endif
  end

  // Result slot: a multiply start frees the slot, since in_ready implied it was drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
    end else if (accept && !mul_start) begin
      out_valid <= 1'b1;
      res       <= alu_res;
      zero      <= ~|alu_res;
      overflow  <= alu_ovf;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      res       <= mul_res;
      zero      <= ~|mul_res;
      overflow  <= 1'b0;
    end else if (accept || (out_valid && out_ready)) begin
      out_valid <= 1'b0;
    end
  end

endmodule
